// File: rtl/flash_timer_pkg.sv
// Shared definitions for the flash timer bank: channel state encoding,
// display mode constants and default timing constants for a 50 MHz clock.
package flash_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam logic MODE_STEADY = 1'b0;
  localparam logic MODE_BLINK  = 1'b1;

  // 1 ms tick at 50 MHz
  localparam int TICK_DIV_1MS       = 50000;
  localparam int BLINK_HALF_DEFAULT = 250;
  localparam int CNT_W_DEFAULT      = 16;
  localparam int CHANNELS_DEFAULT   = 4;

endpackage

// File: rtl/flash_timer_channel.sv
// One flash timer channel: turns a start request into a window of
// 'duration' ticks, steady or blinking, with abort, retrigger and a
// one-cycle completion pulse. All outputs come straight from registers.
module flash_timer_channel
  import flash_timer_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int BLINK_HALF = BLINK_HALF_DEFAULT,
  parameter int RETRIGGER  = 1
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             blink,
  input  logic [CNT_W-1:0] duration,
  output logic             active,
  output logic             flash,
  output logic             done
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF + 1) : 1;
  localparam logic [BW-1:0] BHALF = BW'(BLINK_HALF);
  localparam logic RETRIG_EN = (RETRIGGER != 0);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    bcnt;
  logic             phase;
  logic             mode;
  logic             dur_zero;

  assign dur_zero = (duration == '0);

  // Channel FSM with duration counter, blink divider and registered outputs
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bcnt   <= '0;
      phase  <= 1'b0;
      mode   <= MODE_STEADY;
      active <= 1'b0;
      flash  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // stop beats a coincident start; a zero-length start just reports done
          if (start && !stop) begin
            if (!dur_zero) begin
              state  <= ST_RUN;
              cnt    <= duration;
              mode   <= blink;
              phase  <= 1'b1;
              bcnt   <= BHALF;
              active <= 1'b1;
              flash  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            // abort: silent return to idle
            state  <= ST_IDLE;
            phase  <= 1'b0;
            active <= 1'b0;
            flash  <= 1'b0;
          end else if (RETRIG_EN && start) begin
            // reload takes priority over a coincident expiry tick
            if (!dur_zero) begin
              cnt    <= duration;
              mode   <= blink;
              phase  <= 1'b1;
              bcnt   <= BHALF;
              flash  <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              phase  <= 1'b0;
              active <= 1'b0;
              flash  <= 1'b0;
              done   <= 1'b1;
            end
          end else if (tick) begin
            if (cnt == CNT_W'(1)) begin
              // natural expiry
              state  <= ST_IDLE;
              phase  <= 1'b0;
              active <= 1'b0;
              flash  <= 1'b0;
              done   <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
              if (mode == MODE_BLINK) begin
                if (bcnt == BW'(1)) begin
                  bcnt  <= BHALF;
                  phase <= ~phase;
                  flash <= ~phase;
                end else begin
                  bcnt <= bcnt - BW'(1);
                end
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/flash_timer_bank.sv
// Bank of independent flash timer channels sharing a single tick prescaler.
module flash_timer_bank
  import flash_timer_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int TICK_DIV   = TICK_DIV_1MS,
  parameter int BLINK_HALF = BLINK_HALF_DEFAULT,
  parameter int RETRIGGER  = 1
) (
  input  logic                CLK_50MHZ,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CHANNELS-1:0] blink,
  input  logic [CNT_W-1:0]    duration,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] flash,
  output logic [CHANNELS-1:0] done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  // With TICK_DIV=1 the counter sits at 0 and tick is permanently high
  assign tick = (pcnt == PLAST);

  // Free-running prescaler; starts never disturb it
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    flash_timer_channel #(
      .CNT_W      (CNT_W),
      .BLINK_HALF (BLINK_HALF),
      .RETRIGGER  (RETRIGGER)
    ) u_ch (
      .CLK_50MHZ (CLK_50MHZ),
      .RST_N     (RST_N),
      .tick      (tick),
      .start     (start[g]),
      .stop      (stop[g]),
      .blink     (blink[g]),
      .duration  (duration),
      .active    (active[g]),
      .flash     (flash[g]),
      .done      (done[g])
    );
  end

endmodule

// File: tb/tb_flash_timer_bank.sv
// Testbench for flash_timer_bank: three bank configurations share one
// stimulus stream; a tick-level reference model predicts every output cycle.
module tb_flash_timer_bank;

  logic       CLK_50MHZ = 1'b0;
  logic       RST_N     = 1'b1;
  logic [3:0] start     = '0;
  logic [3:0] stop      = '0;
  logic [3:0] blink     = '0;
  logic [7:0] duration  = '0;

  logic [3:0] act [3];
  logic [3:0] fl  [3];
  logic [3:0] dn  [3];

  // configuration of each DUT: tick divider, blink half-period, retrigger
  int td [3] = '{1, 1, 4};
  int bh [3] = '{2, 2, 3};
  int rt [3] = '{1, 0, 1};

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  flash_timer_bank #(.CHANNELS(4), .CNT_W(8), .TICK_DIV(1), .BLINK_HALF(2), .RETRIGGER(1)) u_dut0 (
    .CLK_50MHZ(CLK_50MHZ), .RST_N(RST_N), .start(start), .stop(stop), .blink(blink),
    .duration(duration), .active(act[0]), .flash(fl[0]), .done(dn[0]));

  flash_timer_bank #(.CHANNELS(4), .CNT_W(8), .TICK_DIV(1), .BLINK_HALF(2), .RETRIGGER(0)) u_dut1 (
    .CLK_50MHZ(CLK_50MHZ), .RST_N(RST_N), .start(start), .stop(stop), .blink(blink),
    .duration(duration), .active(act[1]), .flash(fl[1]), .done(dn[1]));

  flash_timer_bank #(.CHANNELS(4), .CNT_W(8), .TICK_DIV(4), .BLINK_HALF(3), .RETRIGGER(1)) u_dut2 (
    .CLK_50MHZ(CLK_50MHZ), .RST_N(RST_N), .start(start), .stop(stop), .blink(blink),
    .duration(duration), .active(act[2]), .flash(fl[2]), .done(dn[2]));

  // reference model: per channel, running flag, window length, ticks elapsed
  bit m_run  [3][4];
  int m_dur  [3][4];
  int m_el   [3][4];
  bit m_mode [3][4];
  bit m_done [3][4];
  int m_k    [3];

  logic [35:0] exp_q [$];
  bit running = 1'b0;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_k[d] = 0;
      for (int c = 0; c < 4; c++) begin
        m_run[d][c] = 0; m_dur[d][c] = 0; m_el[d][c] = 0;
        m_mode[d][c] = 0; m_done[d][c] = 0;
      end
    end
  endfunction

  function automatic void model_step(logic [3:0] st, logic [3:0] sp, logic [3:0] bl, logic [7:0] dur);
    bit tk;
    for (int d = 0; d < 3; d++) begin
      tk = ((m_k[d] % td[d]) == td[d] - 1);
      for (int c = 0; c < 4; c++) begin
        m_done[d][c] = 0;
        if (!m_run[d][c]) begin
          if (st[c] && !sp[c]) begin
            if (dur != 0) begin
              m_run[d][c] = 1; m_dur[d][c] = int'(dur); m_el[d][c] = 0; m_mode[d][c] = bl[c];
            end else begin
              m_done[d][c] = 1;
            end
          end
        end else if (sp[c]) begin
          m_run[d][c] = 0;
        end else if (st[c] && rt[d] != 0) begin
          if (dur != 0) begin
            m_dur[d][c] = int'(dur); m_el[d][c] = 0; m_mode[d][c] = bl[c];
          end else begin
            m_run[d][c] = 0; m_done[d][c] = 1;
          end
        end else if (tk) begin
          if (m_el[d][c] + 1 == m_dur[d][c]) begin
            m_run[d][c] = 0; m_done[d][c] = 1;
          end else begin
            m_el[d][c]++;
          end
        end
      end
      m_k[d]++;
    end
  endfunction

  // expected {active, flash, done} of each DUT, 12 bits per DUT
  function automatic logic [35:0] model_out();
    logic [35:0] r;
    bit f;
    r = '0;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        f = m_run[d][c] && (!m_mode[d][c] || ((m_el[d][c] / bh[d]) % 2 == 0));
        r[d*12 + 8 + c] = m_run[d][c];
        r[d*12 + 4 + c] = f;
        r[d*12 + c]     = m_done[d][c];
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] bl, input logic [7:0] dur);
    start = st; stop = sp; blink = bl; duration = dur;
    if (RST_N) model_step(st, sp, bl, dur);
    else model_reset();
    exp_q.push_back(model_out());
    running = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] bl, input logic [7:0] dur);
    @(negedge CLK_50MHZ);
    drive(st, sp, bl, dur);
  endtask

  task automatic idle(input int n);
    logic [7:0] junk;
    for (int i = 0; i < n; i++) begin
      junk = 8'($urandom);
      cycle(4'h0, 4'h0, 4'h0, junk);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({act[d], fl[d], dn[d]} === 12'h000) n_pass++;
      else $display("FAIL %s dut%0d got act/flash/done=%b/%b/%b required 0/0/0", tag, d, act[d], fl[d], dn[d]);
    end
  endtask

  // asynchronous reset mid-cycle, held for 'hold' edges, released at a negedge
  task automatic do_reset(input int hold);
    @(negedge CLK_50MHZ);
    RST_N = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    exp_q.push_back(model_out());
    for (int i = 1; i < hold; i++) cycle(4'h0, 4'h0, 4'h0, 8'h0);
    @(negedge CLK_50MHZ);
    RST_N = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 8'h0);
  endtask

  // monitor: pop one expectation per clock and compare every DUT
  initial begin
    logic [35:0] e;
    forever begin
      @(posedge CLK_50MHZ);
      #1;
      cyc++;
      if (running) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL queue_underflow cyc%0d got empty queue required an expectation", cyc);
        end else begin
          e = exp_q.pop_front();
          for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({act[d], fl[d], dn[d]} === e[d*12 +: 12]) n_pass++;
            else $display("FAIL outputs dut%0d cyc%0d got act/flash/done=%b/%b/%b required %b/%b/%b",
                          d, cyc, act[d], fl[d], dn[d], e[d*12+8 +: 4], e[d*12+4 +: 4], e[d*12 +: 4]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] st, sp, bl;
    logic [7:0] dur;
    int r;
    model_reset();
    #1 RST_N = 1'b0;
    #1 check_zero("reset_state");
    idle(3);
    @(negedge CLK_50MHZ);
    RST_N = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 8'h0);
    idle(2);

    // steady window of 5 on channel 0
    cycle(4'b0001, 4'h0, 4'h0, 8'd5);  idle(8);
    // blinking window of 8 on channel 1
    cycle(4'b0010, 4'h0, 4'b0010, 8'd8); idle(12);
    // abort on the 4th active cycle, then start+stop together while idle
    cycle(4'b0100, 4'h0, 4'h0, 8'd10); idle(3);
    cycle(4'h0, 4'b0100, 4'h0, 8'd10); idle(4);
    cycle(4'b0100, 4'b0100, 4'h0, 8'd7); idle(4);
    // retrigger at active cycle 4
    cycle(4'b1000, 4'h0, 4'h0, 8'd6); idle(3);
    cycle(4'b1000, 4'h0, 4'h0, 8'd3); idle(10);
    // zero-length start
    cycle(4'b0001, 4'h0, 4'h0, 8'd0); idle(3);
    // retrigger with zero length while running
    cycle(4'b0010, 4'h0, 4'h0, 8'd9); idle(2);
    cycle(4'b0010, 4'h0, 4'h0, 8'd0); idle(6);
    // all channels together, then reset mid-run
    cycle(4'b1111, 4'h0, 4'b0101, 8'd20); idle(5);
    do_reset(2); idle(6);
    // maximum window length on channel 0
    cycle(4'b0001, 4'h0, 4'b0001, 8'd255); idle(262);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset(2);
      for (int c = 0; c < 4; c++) begin
        st[c] = ($urandom_range(0, 11) == 0);
        sp[c] = ($urandom_range(0, 29) == 0);
        bl[c] = 1'($urandom_range(0, 1));
      end
      r = int'($urandom_range(0, 9));
      if (r == 0) dur = 8'd0;
      else if (r < 8) dur = 8'($urandom_range(1, 12));
      else dur = 8'($urandom_range(1, 40));
      cycle(st, sp, bl, dur);
    end
    idle(20);

    @(posedge CLK_50MHZ);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    end
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_timer_bank.md
Name: flash_timer_bank

Overview:
- Multi-channel successor to the single flash timer on the scoreboard display path.
- Each channel turns a one-cycle start request into a timed flash window. Windows last a programmable number of prescaled ticks, in steady or blinking mode.
- Each channel supports retrigger, abort and a completion pulse.
- Sits between the score/control logic and the display drivers. All channels share one prescaler.

Parameters:
- CHANNELS, 4, number of independent timer channels.
- CNT_W, 16, width of the duration counter in ticks.
- TICK_DIV, 50000, clock cycles per tick (1 ms at 50 MHz). Value 1 means a tick every cycle.
- BLINK_HALF, 250, ticks per blink half-period; must be ≥1.
- RETRIGGER, 1, 1 = a start while running reloads the channel; 0 = the start is ignored.

Ports:
- CLK_50MHZ  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  CHANNELS  per-channel one-cycle start request.
- stop  in  CHANNELS  per-channel one-cycle abort request.
- blink  in  CHANNELS  per-channel mode, sampled with start: 1 = blink, 0 = steady.
- duration  in  CNT_W  shared window length in ticks, sampled with any accepted start.
- active  out  CHANNELS  channel is running.
- flash  out  CHANNELS  drive to the display element.
- done  out  CHANNELS  one-cycle pulse on natural expiry.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - prescaler=0; every channel IDLE.
  - active=0, flash=0, done=0.
  - All counters, phase bits and latched modes cleared.
  - Reset during a run aborts it with no done pulse.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 in the cycle the count equals TICK_DIV-1, then the counter wraps to 0.
  - Never reset by start.
- Per-channel states: IDLE, RUN. All outputs are registered.
- IDLE, start=1, stop=0, duration≠0:
  - Next edge: RUN, cnt=duration, mode=blink, phase=on, bcnt=BLINK_HALF.
  - active=1 from the following cycle.
- IDLE, start=1, duration=0: stay IDLE; done=1 for one cycle next edge; flash stays 0.
- RUN, on each tick:
  - cnt decrements.
  - If cnt==1 at the tick: next edge IDLE, active=0, flash=0, done=1 for exactly one cycle.
- Window length: active lasts duration ticks, with a first-tick phase error of up to TICK_DIV-1 cycles. With TICK_DIV=1, active is high for exactly duration cycles.
- Blink mode:
  - bcnt decrements on each tick; at bcnt==1 it reloads BLINK_HALF and phase toggles.
  - flash = active AND phase.
- Steady mode: flash = active.
- stop while RUN: next edge IDLE, active=0, flash=0, no done pulse.
- stop while IDLE: no effect.
- start and stop in the same cycle: stop wins; the start is discarded; a running channel aborts.
- start while RUN:
  - RETRIGGER=1: reload cnt=duration, re-latch mode, phase=on, bcnt=BLINK_HALF; no done pulse. If duration=0, the channel expires with a done pulse.
  - RETRIGGER=0: the request is ignored.
- Start coinciding with the expiry tick:
  - RETRIGGER=1: the reload wins and done is suppressed.
  - RETRIGGER=0: the channel expires and the start is lost.
- Channels are fully independent. Simultaneous starts on several channels all sample the same duration value.
- cnt saturates naturally: the maximum window is 2^CNT_W-1 ticks; no wrap-around is possible because reload only occurs on start.

Decomposition:
- Package flash_timer_pkg holds:
  - the state encoding (IDLE, RUN);
  - mode constants (MODE_STEADY, MODE_BLINK);
  - default parameter constants for 50 MHz (TICK_DIV_1MS=50000).
- Sub-module flash_timer_channel contains one channel's FSM, duration counter, blink counter and output registers. It takes tick as an input.
- The top level holds the shared prescaler plus a generate loop over CHANNELS.

Test Plan:
- TICK_DIV=1: start[0] with duration=5, blink=0 → active[0]/flash[0] high exactly 5 cycles starting one cycle after start. done[0] pulses once, in the cycle after active falls.
- TICK_DIV=1, BLINK_HALF=2: start[1] with duration=8, blink=1 → flash[1] pattern 1,1,0,0,1,1,0,0 while active; then done.
- duration=10 running: stop[2] at the 4th active cycle → active/flash low next cycle; done never asserts. Then start and stop together in IDLE → channel stays IDLE.
- RETRIGGER=1: start, duration=6; at active cycle 4, start with duration=3 → active totals 4+3 cycles, one done pulse. With RETRIGGER=0 → total 6, second start ignored.
- duration=0 start → done pulse next cycle, active never set. Assert RST_N=0 mid-run on all 4 channels → all outputs 0 immediately, no done after release.
- TICK_DIV=4: start duration=3 → active length between 9 and 12 cycles. Concurrent starts on all channels → identical active waveforms.
